// File: rtl/motoro3_pkg.sv
// Shared types and defaults for the phase-line monitor: FSM states,
// last-conducting-side encoding and the default counter widths.
package motoro3_pkg;

    localparam int CNT_W_DEF = 25;
    localparam int PWM_W_DEF = 16;

    // Zero-crossing detector states
    typedef enum logic [1:0] {
        S_DRIVEN = 2'd0,
        S_BLANK  = 2'd1,
        S_WATCH  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Which gate was last seen conducting on its own
    typedef enum logic [1:0] {
        SIDE_NONE = 2'd0,
        SIDE_HIGH = 2'd1,
        SIDE_LOW  = 2'd2
    } side_t;

    // Update the last-conducting side; overlap (shoot-through) or idle keeps the old value
    function automatic side_t next_side(input logic hp, input logic lp, input side_t prev);
        side_t s;
        if (hp && !lp) begin
            s = SIDE_HIGH;
        end else if (lp && !hp) begin
            s = SIDE_LOW;
        end else begin
            s = prev;
        end
        return s;
    endfunction

endpackage

// File: rtl/motoro3_line_monitor_if.sv
// Phase-line bundle between a line generator (master) and its monitor (slave).
interface motoro3_line_monitor_if
    import motoro3_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int PWM_W = PWM_W_DEF
);
    logic             lmHp;
    logic             lmLp;
    logic             lmEnable;
    logic [3:0]       lmStep;
    logic             lmBemfCmp;
    logic             lmFaultClr;
    logic [PWM_W-1:0] lmPwmHigh;
    logic [PWM_W-1:0] lmPwmPeriod;
    logic             lmPwmValid;
    logic             lmZcPulse;
    logic [CNT_W-1:0] lmZcTime;
    logic             lmZcMiss;
    logic             lmFaultShoot;
    logic             lmFaultDead;

    modport master (
        output lmHp, lmLp, lmEnable, lmStep, lmBemfCmp, lmFaultClr,
        input  lmPwmHigh, lmPwmPeriod, lmPwmValid, lmZcPulse, lmZcTime,
               lmZcMiss, lmFaultShoot, lmFaultDead
    );

    modport slave (
        input  lmHp, lmLp, lmEnable, lmStep, lmBemfCmp, lmFaultClr,
        output lmPwmHigh, lmPwmPeriod, lmPwmValid, lmZcPulse, lmZcTime,
               lmZcMiss, lmFaultShoot, lmFaultDead
    );
endinterface

// File: rtl/motoro3_sync_filter.sv
// Two-flop synchronizer followed by a run-length filter: the output only
// moves to a new level after FILT_N consecutive synced samples agree on it.
module motoro3_sync_filter
    import motoro3_pkg::*;
#(
    parameter int FILT_N = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    localparam int FW = (FILT_N > 1) ? $clog2(FILT_N) : 1;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [FW-1:0] r_run;

    // Synchronize the async input and accept a new level after FILT_N agreeing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_run   <= '0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_level) begin
                if (r_run == FW'(FILT_N - 1)) begin
                    r_level <= r_sync2;
                    r_run   <= '0;
                end else begin
                    r_run <= r_run + FW'(1);
                end
            end else begin
                r_run <= '0;
            end
        end
    end

    assign dout = r_level;

endmodule

// File: rtl/motoro3_line_monitor.sv
// Far-side monitor for one motor phase: PWM high/period measurement,
// shoot-through and dead-time fault flags, and back-EMF zero-crossing
// detection timestamped from the last commutation step change.
module motoro3_line_monitor
    import motoro3_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int PWM_W     = PWM_W_DEF,
    parameter int DEAD_MIN  = 5,
    parameter int BLANK_CYC = 20,
    parameter int FILT_N    = 3
) (
    input  logic clk,
    input  logic rst,
    motoro3_line_monitor_if.slave lm_bus
);
    localparam int DW = $clog2(DEAD_MIN + 1);

    // Registered copies of the line inputs plus one more stage for edge detection
    logic             r_hp;
    logic             r_lp;
    logic             r_en;
    logic [3:0]       r_step;
    logic             r_hp_d;
    logic             r_lp_d;
    logic [3:0]       r_step_d;

    // Dead-time tracking and sticky faults
    logic [DW-1:0]    r_dead_cnt;
    side_t            r_last;
    logic             r_fault_shoot;
    logic             r_fault_dead;

    // PWM measurement
    logic [PWM_W-1:0] r_hi_cnt;
    logic [PWM_W-1:0] r_per_cnt;
    logic [PWM_W-1:0] r_pwm_high;
    logic [PWM_W-1:0] r_pwm_period;
    logic             r_pwm_valid;
    logic             r_seen_rise;

    // Step timer and zero-crossing FSM
    logic [CNT_W-1:0] r_step_cnt;
    state_t           r_state;
    logic             r_ref;
    logic             r_zc_pulse;
    logic [CNT_W-1:0] r_zc_time;
    logic             r_zc_miss;

    logic             w_bf;
    logic             w_hp_rise;
    logic             w_lp_rise;
    logic             w_step_chg;
    logic             w_shoot;
    logic             w_dead_short;
    logic             w_dead_viol;

    motoro3_sync_filter #(
        .FILT_N (FILT_N)
    ) u_bemf_filt (
        .clk  (clk),
        .rst  (rst),
        .din  (lm_bus.lmBemfCmp),
        .dout (w_bf)
    );

    assign w_hp_rise    = r_hp & ~r_hp_d;
    assign w_lp_rise    = r_lp & ~r_lp_d;
    assign w_step_chg   = (r_step != r_step_d);
    assign w_shoot      = r_hp & r_lp;
    assign w_dead_short = (r_dead_cnt < DW'(DEAD_MIN));
    // Only an opposite-side hand-over is checked; same-side PWM re-rises are free
    assign w_dead_viol  = w_dead_short &&
                          ((w_lp_rise && (r_last == SIDE_HIGH)) ||
                           (w_hp_rise && (r_last == SIDE_LOW)));

    // Register the gate/enable/step inputs and keep a delayed copy for edges
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hp     <= 1'b0;
            r_lp     <= 1'b0;
            r_en     <= 1'b0;
            r_step   <= 4'd0;
            r_hp_d   <= 1'b0;
            r_lp_d   <= 1'b0;
            r_step_d <= 4'd0;
        end else begin
            r_hp     <= lm_bus.lmHp;
            r_lp     <= lm_bus.lmLp;
            r_en     <= lm_bus.lmEnable;
            r_step   <= lm_bus.lmStep;
            r_hp_d   <= r_hp;
            r_lp_d   <= r_lp;
            r_step_d <= r_step;
        end
    end

    // Count idle (both gates off) cycles and remember which side conducted last
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dead_cnt <= '0;
            r_last     <= SIDE_NONE;
        end else begin
            if (!r_hp && !r_lp) begin
                if (w_dead_short) begin
                    r_dead_cnt <= r_dead_cnt + DW'(1);
                end else begin
                    r_dead_cnt <= r_dead_cnt;
                end
            end else begin
                r_dead_cnt <= '0;
            end
            r_last <= next_side(r_hp, r_lp, r_last);
        end
    end

    // Sticky fault flags; a fault in the same cycle as the clear keeps the flag set
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault_shoot <= 1'b0;
            r_fault_dead  <= 1'b0;
        end else begin
            if (w_shoot) begin
                r_fault_shoot <= 1'b1;
            end else if (lm_bus.lmFaultClr) begin
                r_fault_shoot <= 1'b0;
            end else begin
                r_fault_shoot <= r_fault_shoot;
            end
            if (w_dead_viol) begin
                r_fault_dead <= 1'b1;
            end else if (lm_bus.lmFaultClr) begin
                r_fault_dead <= 1'b0;
            end else begin
                r_fault_dead <= r_fault_dead;
            end
        end
    end

    // Measure Hp high time and rise-to-rise period, latching both on each rise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi_cnt     <= '0;
            r_per_cnt    <= '0;
            r_pwm_high   <= '0;
            r_pwm_period <= '0;
            r_pwm_valid  <= 1'b0;
            r_seen_rise  <= 1'b0;
        end else if (w_hp_rise) begin
            r_pwm_high   <= r_hi_cnt;
            r_pwm_period <= r_per_cnt;
            r_pwm_valid  <= r_seen_rise;
            r_seen_rise  <= 1'b1;
            r_hi_cnt     <= PWM_W'(1);
            r_per_cnt    <= PWM_W'(1);
        end else begin
            r_pwm_valid <= 1'b0;
            if (!(&r_per_cnt)) begin
                r_per_cnt <= r_per_cnt + PWM_W'(1);
            end else begin
                r_per_cnt <= r_per_cnt;
            end
            if (r_hp && !(&r_hi_cnt)) begin
                r_hi_cnt <= r_hi_cnt + PWM_W'(1);
            end else begin
                r_hi_cnt <= r_hi_cnt;
            end
        end
    end

    // Cycles since the last registered step change, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            r_step_cnt <= '0;
        end else if (w_step_chg) begin
            r_step_cnt <= '0;
        end else if (!(&r_step_cnt)) begin
            r_step_cnt <= r_step_cnt + CNT_W'(1);
        end else begin
            r_step_cnt <= r_step_cnt;
        end
    end

    // Zero-crossing FSM: blank after a floating step change, then watch bf for a change
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_DRIVEN;
            r_ref      <= 1'b0;
            r_zc_pulse <= 1'b0;
            r_zc_time  <= '0;
            r_zc_miss  <= 1'b0;
        end else begin
            r_zc_pulse <= 1'b0;
            r_zc_miss  <= 1'b0;
            if (w_step_chg) begin
                // Step change outranks a crossing seen in the same cycle
                r_state <= r_en ? S_DRIVEN : S_BLANK;
                if ((r_state == S_BLANK) || (r_state == S_WATCH)) begin
                    r_zc_miss <= 1'b1;
                end
            end else begin
                case (r_state)
                    S_DRIVEN: begin
                        r_state <= S_DRIVEN;
                    end
                    S_BLANK: begin
                        if (r_en) begin
                            r_state <= S_DRIVEN;
                        end else if (r_step_cnt == CNT_W'(BLANK_CYC - 1)) begin
                            r_ref   <= w_bf;
                            r_state <= S_WATCH;
                        end else begin
                            r_state <= S_BLANK;
                        end
                    end
                    S_WATCH: begin
                        if (r_en) begin
                            r_state <= S_DRIVEN;
                        end else if (w_bf != r_ref) begin
                            r_zc_pulse <= 1'b1;
                            r_zc_time  <= r_step_cnt;
                            r_state    <= S_DONE;
                        end else begin
                            r_state <= S_WATCH;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_DONE;
                    end
                    default: begin
                        r_state <= S_DRIVEN;
                    end
                endcase
            end
        end
    end

    assign lm_bus.lmPwmHigh    = r_pwm_high;
    assign lm_bus.lmPwmPeriod  = r_pwm_period;
    assign lm_bus.lmPwmValid   = r_pwm_valid;
    assign lm_bus.lmZcPulse    = r_zc_pulse;
    assign lm_bus.lmZcTime     = r_zc_time;
    assign lm_bus.lmZcMiss     = r_zc_miss;
    assign lm_bus.lmFaultShoot = r_fault_shoot;
    assign lm_bus.lmFaultDead  = r_fault_dead;

endmodule
